// File: rtl/rx_module_if.sv
// Receiver-side bus: baud tick, enable/config, serial line in, received word and status out.
interface rx_module_if;
    logic       baud_en_i;
    logic       rx_en_i;
    logic [4:0] rx_conf_i;
    logic       uart_rx_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_parity_err_o;
    logic       rx_frame_err_o;
    logic       rx_busy_o;

    modport master (
        output baud_en_i, rx_en_i, rx_conf_i, uart_rx_i,
        input  rx_data_o, rx_valid_o, rx_parity_err_o, rx_frame_err_o, rx_busy_o
    );

    modport slave (
        input  baud_en_i, rx_en_i, rx_conf_i, uart_rx_i,
        output rx_data_o, rx_valid_o, rx_parity_err_o, rx_frame_err_o, rx_busy_o
    );
endinterface

// File: rtl/rx_module.sv
// UART receiver: 16x oversampled, 5-8 data bits, optional even parity, 1 or 2 stop bits.
module rx_module #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    rx_module_if.slave  bus
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CONF_W = 5;

    typedef enum logic [2:0] {
        S_RESET, S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx;

    state_t              r_state,   w_state_nxt;
    logic [CNT_W-1:0]    r_cnt,     w_cnt_nxt;
    logic                r_armed,   w_armed_nxt;
    logic [BIT_W-1:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic                r_stop_cnt, w_stop_cnt_nxt;
    logic [DATA_W-1:0]   r_shift,   w_shift_nxt;
    logic                r_par,     w_par_nxt;
    logic                r_perr,    w_perr_nxt;
    logic                r_ferr,    w_ferr_nxt;
    logic [CONF_W-1:0]   r_conf,    w_conf_nxt;
    logic [DATA_W-1:0]   r_data,    w_data_nxt;
    logic                r_valid,   w_valid_nxt;
    logic                r_perr_o,  w_perr_o_nxt;
    logic                r_ferr_o,  w_ferr_o_nxt;
    logic                r_busy,    w_busy_nxt;

    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_cnt_wrap;
    logic [BIT_W-1:0]    w_last_bit;
    logic                w_last_stop;
    logic                w_ferr_acc;

    // Synchronise the asynchronous line; idles high out of reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_sync <= '1;
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], bus.uart_rx_i};
    end

    assign w_rx        = r_sync[SYNC_STAGES-1];
    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    assign w_cnt_wrap  = (r_cnt == CNT_W'(15));
    assign w_last_bit  = BIT_W'(4) + {1'b0, r_conf[4:3]};
    assign w_last_stop = (r_stop_cnt == (|r_conf[2:1]));
    assign w_ferr_acc  = r_ferr | ~w_rx;

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= S_RESET;
            r_cnt      <= '0;
            r_armed    <= 1'b0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_conf     <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr_o   <= 1'b0;
            r_ferr_o   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_armed    <= w_armed_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_par      <= w_par_nxt;
            r_perr     <= w_perr_nxt;
            r_ferr     <= w_ferr_nxt;
            r_conf     <= w_conf_nxt;
            r_data     <= w_data_nxt;
            r_valid    <= w_valid_nxt;
            r_perr_o   <= w_perr_o_nxt;
            r_ferr_o   <= w_ferr_o_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // Next-state and output logic; everything except leaving Done waits for a baud tick.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_armed_nxt    = r_armed;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_shift_nxt    = r_shift;
        w_par_nxt      = r_par;
        w_perr_nxt     = r_perr;
        w_ferr_nxt     = r_ferr;
        w_conf_nxt     = r_conf;
        w_data_nxt     = r_data;
        w_valid_nxt    = 1'b0;
        w_perr_o_nxt   = r_perr_o;
        w_ferr_o_nxt   = r_ferr_o;
        w_busy_nxt     = r_busy;

        unique case (r_state)
            S_RESET: begin
                if (bus.baud_en_i && bus.rx_en_i) begin
                    w_state_nxt = S_IDLE;
                    w_armed_nxt = 1'b0;
                end
            end
            S_IDLE: begin
                if (bus.baud_en_i) begin
                    if (!bus.rx_en_i) begin
                        w_state_nxt = S_RESET;
                    end else if (!r_armed) begin
                        w_armed_nxt = w_rx;
                    end else if (!w_rx) begin
                        w_state_nxt = S_START;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            S_START: begin
                if (bus.baud_en_i) begin
                    if (r_cnt == CNT_W'(7)) begin
                        w_cnt_nxt = '0;
                        if (w_rx) begin
                            // Start bit did not hold to mid-bit: treat as a glitch.
                            w_state_nxt = S_IDLE;
                            w_armed_nxt = 1'b0;
                        end else begin
                            w_state_nxt    = S_DATA;
                            w_conf_nxt     = bus.rx_conf_i;
                            w_busy_nxt     = 1'b1;
                            w_bit_cnt_nxt  = '0;
                            w_stop_cnt_nxt = 1'b0;
                            w_shift_nxt    = '0;
                            w_par_nxt      = 1'b0;
                            w_perr_nxt     = 1'b0;
                            w_ferr_nxt     = 1'b0;
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            S_DATA: begin
                if (bus.baud_en_i) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_wrap) begin
                        w_shift_nxt[r_bit_cnt] = w_rx;
                        w_par_nxt              = r_par ^ w_rx;
                        if (r_bit_cnt == w_last_bit) begin
                            w_state_nxt = r_conf[0] ? S_PARITY : S_STOP;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
                        end
                    end
                end
            end
            S_PARITY: begin
                if (bus.baud_en_i) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_wrap) begin
                        w_perr_nxt  = r_par ^ w_rx;
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (bus.baud_en_i) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_wrap) begin
                        w_ferr_nxt = w_ferr_acc;
                        if (w_last_stop) begin
                            // Publish the frame on entry to Done so valid lands one clk after the tick.
                            w_state_nxt  = S_DONE;
                            w_data_nxt   = r_shift;
                            w_perr_o_nxt = r_perr;
                            w_ferr_o_nxt = w_ferr_acc;
                            w_valid_nxt  = 1'b1;
                            w_busy_nxt   = 1'b0;
                        end else begin
                            w_stop_cnt_nxt = 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_armed_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = S_RESET;
            end
        endcase
    end

    assign bus.rx_data_o       = r_data;
    assign bus.rx_valid_o      = r_valid;
    assign bus.rx_parity_err_o = r_perr_o;
    assign bus.rx_frame_err_o  = r_ferr_o;
    assign bus.rx_busy_o       = r_busy;
endmodule
